// File: rtl/ac_pkg.sv
// Shared types and constants for the AC last-non-zero block buffer.
package ac_pkg;

   localparam int unsigned DEF_BLK_LEN = 64;
   // The metadata index field is wide enough for any BLK_LEN up to 2**16.
   localparam int unsigned META_IDX_W  = 16;

   typedef logic bank_t;

   typedef struct packed {
      logic [META_IDX_W-1:0] last;
      logic                  zero;
      logic                  trunc;
   } meta_t;

   typedef struct packed {
      logic  full;
      meta_t meta;
   } bank_state_t;

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_FILL = 1'b1
   } wr_state_e;

   function automatic int unsigned blk_last_idx(input int unsigned blk_len);
      return blk_len - 1;
   endfunction

endpackage

// File: rtl/ac_bank_ram.sv
// Simple dual-port synchronous RAM holding both coefficient banks.
module ac_bank_ram #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

   // Write port and registered read port; rdata holds while re is low.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/ac_last_nz_buffer.sv
// Ping-pong block buffer: captures a zig-zag block, tracks the last non-zero
// index and replays the block (optionally truncated) to the entropy coder.
module ac_last_nz_buffer
   import ac_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned BLK_LEN    = DEF_BLK_LEN,
   parameter int unsigned IDX_WIDTH  = $clog2(BLK_LEN)
) (
   input  logic                  clk_x8_i,
   input  logic                  rst_n_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic                  in_start_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  mode_trunc_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_first_o,
   output logic                  out_last_o,
   output logic [IDX_WIDTH-1:0]  out_len_o,
   output logic                  out_zero_o,
   output logic                  err_start_o
);

   localparam logic [IDX_WIDTH-1:0] IDX_END = IDX_WIDTH'(blk_last_idx(BLK_LEN));

   wr_state_e            wr_state, wr_state_nxt;
   logic [IDX_WIDTH-1:0] wr_idx, wr_addr, run_last;
   logic                 run_nz, trunc_q, rdy_en;
   bank_t                wr_bank, rd_bank, iss_bank, s1_bank;
   bank_state_t          bank_st [2];
   logic [1:0]           iss_done;
   logic [IDX_WIDTH-1:0] iss_idx, end_idx;
   logic                 s1_v, s1_first, s1_last;
   logic                 accept, beat_nz, ram_we, commit, err_nxt;
   logic                 issue, iss_end, out_adv, s1_adv, release_bank;
   logic [DATA_WIDTH-1:0] ram_rdata;
   meta_t                iss_meta;

   assign accept     = in_valid_i & in_ready_o;
   assign beat_nz    = |in_data_i;
   assign wr_addr    = in_start_i ? '0 : wr_idx;
   assign in_ready_o = rdy_en & ~bank_st[wr_bank].full;

   // Write-side state register.
   always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
      if (!rst_n_i) wr_state <= WR_IDLE;
      else          wr_state <= wr_state_nxt;
   end

   // Write-side next state: start handling, abort/drop errors, commit.
   always_comb begin
      wr_state_nxt = wr_state;
      err_nxt      = 1'b0;
      ram_we       = 1'b0;
      commit       = 1'b0;
      if (accept) begin
         if (in_start_i) begin
            ram_we       = 1'b1;
            err_nxt      = (wr_state == WR_FILL);
            wr_state_nxt = WR_FILL;
         end else if (wr_state == WR_IDLE) begin
            err_nxt = 1'b1;
         end else begin
            ram_we = 1'b1;
            if (wr_idx == IDX_END) begin
               commit       = 1'b1;
               wr_state_nxt = WR_IDLE;
            end
         end
      end
   end

   // Write counter, last-index tracker, write bank pointer and error pulse.
   always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_idx      <= '0;
         run_last    <= '0;
         run_nz      <= 1'b0;
         trunc_q     <= 1'b0;
         wr_bank     <= 1'b0;
         rdy_en      <= 1'b0;
         err_start_o <= 1'b0;
      end else begin
         rdy_en      <= 1'b1;
         err_start_o <= err_nxt;
         if (accept && in_start_i) begin
            wr_idx   <= IDX_WIDTH'(1);
            run_last <= '0;
            run_nz   <= beat_nz;
            trunc_q  <= mode_trunc_i;
         end else if (ram_we) begin
            wr_idx <= wr_idx + 1'b1;
            if (beat_nz) begin
               run_last <= wr_idx;
               run_nz   <= 1'b1;
            end
            if (commit) wr_bank <= ~wr_bank;
         end
      end
   end

   // Bank FULL flags, metadata and issue-complete flags; commit and release
   // always target different banks, so both are honoured in one cycle.
   always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int unsigned b = 0; b < 2; b++) bank_st[b] <= '0;
         iss_done <= '0;
      end else begin
         for (int unsigned b = 0; b < 2; b++) begin
            if (commit && wr_bank == bank_t'(b)) begin
               bank_st[b].full       <= 1'b1;
               bank_st[b].meta.last  <= META_IDX_W'(beat_nz ? wr_idx : run_last);
               bank_st[b].meta.zero  <= ~(run_nz | beat_nz);
               bank_st[b].meta.trunc <= trunc_q;
            end else if (release_bank && rd_bank == bank_t'(b)) begin
               bank_st[b].full <= 1'b0;
            end
            if (iss_end && iss_bank == bank_t'(b))            iss_done[b] <= 1'b1;
            else if (release_bank && rd_bank == bank_t'(b))   iss_done[b] <= 1'b0;
         end
      end
   end

   // Read pipeline: issue -> RAM register (s1) -> output register.
   // The issue pointer runs ahead of the release pointer so the next bank
   // starts streaming before the current last beat is handshaken.
   assign iss_meta     = bank_st[iss_bank].meta;
   assign end_idx      = iss_meta.trunc ? IDX_WIDTH'(iss_meta.last) : IDX_END;
   assign release_bank = out_valid_o & out_ready_i & out_last_o;
   assign out_adv      = ~out_valid_o | out_ready_i;
   assign s1_adv       = ~s1_v | out_adv;
   assign issue        = s1_adv & bank_st[iss_bank].full & ~iss_done[iss_bank];
   assign iss_end      = issue & (iss_idx == end_idx);

   // Read sequencer, stage-1 sideband and output register.
   always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         iss_idx     <= '0;
         iss_bank    <= 1'b0;
         rd_bank     <= 1'b0;
         s1_v        <= 1'b0;
         s1_first    <= 1'b0;
         s1_last     <= 1'b0;
         s1_bank     <= 1'b0;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_first_o <= 1'b0;
         out_last_o  <= 1'b0;
         out_len_o   <= '0;
         out_zero_o  <= 1'b0;
      end else begin
         if (issue) begin
            iss_idx <= iss_end ? '0 : iss_idx + 1'b1;
            if (iss_end) iss_bank <= ~iss_bank;
         end
         if (s1_adv) begin
            s1_v     <= issue;
            s1_first <= (iss_idx == '0);
            s1_last  <= iss_end;
            s1_bank  <= iss_bank;
         end
         if (out_adv) begin
            out_valid_o <= s1_v;
            if (s1_v) begin
               out_data_o  <= ram_rdata;
               out_first_o <= s1_first;
               out_last_o  <= s1_last;
               out_len_o   <= IDX_WIDTH'(bank_st[s1_bank].meta.last);
               out_zero_o  <= bank_st[s1_bank].meta.zero;
            end
         end
         if (release_bank) rd_bank <= ~rd_bank;
      end
   end

   ac_bank_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (IDX_WIDTH + 1)
   ) u_ram (
      .clk   (clk_x8_i),
      .we    (ram_we),
      .waddr ({wr_bank, wr_addr}),
      .wdata (in_data_i),
      .re    (issue),
      .raddr ({iss_bank, iss_idx}),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_ac_last_nz_buffer.sv
// Self-checking bench for ac_last_nz_buffer: block-level reference model plus
// directed scenarios with literal expectations.
module tb_ac_last_nz_buffer;

   localparam int unsigned BLK = 64;

   typedef struct packed {
      logic [15:0] data;
      logic        first;
      logic        last;
      logic [5:0]  len;
      logic        zero;
   } beat_t;

   typedef struct packed {
      logic [31:0] beats;
      logic [15:0] first_data;
      logic [5:0]  len;
      logic        zero;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_start = 1'b0, mode_trunc = 1'b0;
   logic [15:0] in_data = '0;
   logic        out_ready = 1'b0;
   logic        in_ready_o, out_valid_o, out_first_o, out_last_o, out_zero_o, err_start_o;
   logic [15:0] out_data_o;
   logic [5:0]  out_len_o;

   int unsigned n_pass = 0, n_total = 0;
   int unsigned ready_mode = 0;
   int unsigned err_cnt = 0;
   logic [15:0] cur_blk [BLK];
   beat_t       exp_q [$];
   obs_t        obs_q [$];

   always #5 clk = ~clk;

   ac_last_nz_buffer #(.DATA_WIDTH(16), .BLK_LEN(BLK)) dut (
      .clk_x8_i     (clk),
      .rst_n_i      (rst_n),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready_o),
      .in_start_i   (in_start),
      .in_data_i    (in_data),
      .mode_trunc_i (mode_trunc),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready),
      .out_data_o   (out_data_o),
      .out_first_o  (out_first_o),
      .out_last_o   (out_last_o),
      .out_len_o    (out_len_o),
      .out_zero_o   (out_zero_o),
      .err_start_o  (err_start_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic bound_fail(input string name);
      n_total++;
      $display("FAIL %s: got timeout expected event within bound", name);
   endtask

   // Reference model: expected replay of one committed block.
   task automatic push_expected(input bit trunc);
      int unsigned last = 0, n;
      bit nz = 0;
      beat_t b;
      for (int unsigned i = 0; i < BLK; i++)
         if (cur_blk[i] != 0) begin last = i; nz = 1; end
      n = trunc ? last + 1 : BLK;
      for (int unsigned i = 0; i < n; i++) begin
         b.data = cur_blk[i]; b.first = (i == 0); b.last = (i == n - 1);
         b.len = 6'(last); b.zero = !nz;
         exp_q.push_back(b);
      end
   endtask

   task automatic send_beat(input logic [15:0] d, input bit st, input bit tr);
      bit acc;
      int unsigned n = 0;
      in_valid = 1'b1; in_start = st; in_data = d; mode_trunc = tr;
      do begin
         acc = in_ready_o;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 3000);
      if (!acc) bound_fail("accept_wait");
   endtask

   task automatic send_block(input bit trunc, input int unsigned nbeats);
      for (int unsigned i = 0; i < nbeats; i++) send_beat(cur_blk[i], i == 0, trunc);
      in_valid = 1'b0; in_start = 1'b0;
      if (nbeats == BLK) push_expected(trunc);
   endtask

   task automatic fill_random(input int unsigned density, input int unsigned upto);
      for (int unsigned i = 0; i < BLK; i++)
         cur_blk[i] = (i < upto && $urandom_range(0, 99) < density) ? 16'($urandom) : 16'h0;
   endtask

   task automatic wait_cycles(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int unsigned n = 0;
      while ((exp_q.size() != 0 || out_valid_o) && n < 5000) begin
         @(posedge clk); #1; n++;
      end
      if (exp_q.size() != 0 || out_valid_o) bound_fail("drain_wait");
      wait_cycles(2);
   endtask

   // Output ready driver.
   always begin
      @(posedge clk); #1;
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Compare process: every handshaken beat against the model, hold while stalled.
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = '0;
   int unsigned blk_cnt = 0;
   logic [15:0] blk_first_data = '0;
   always @(negedge clk) begin
      beat_t e, a;
      obs_t  o;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (err_start_o) err_cnt++;
         if (prev_stall) check("hold", {out_valid_o, out_data_o}, {1'b1, prev_data});
         if (out_valid_o && out_ready) begin
            a = {out_data_o, out_first_o, out_last_o, out_len_o, out_zero_o};
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_beat: got beat 0x%0h expected none", a);
            end else begin
               e = exp_q.pop_front();
               check("beat", a, e);
            end
            if (out_first_o) begin blk_cnt = 1; blk_first_data = out_data_o; end
            else blk_cnt++;
            if (out_last_o) begin
               o.beats = blk_cnt; o.first_data = blk_first_data;
               o.len = out_len_o; o.zero = out_zero_o;
               obs_q.push_back(o);
            end
         end
         prev_stall = out_valid_o && !out_ready;
         prev_data  = out_data_o;
      end
   end

   initial begin
      obs_t o;
      int unsigned e0;
      bit saw;

      // Reset state
      wait_cycles(3);
      check("rst_in_ready", in_ready_o, 0);
      check("rst_outs", {out_valid_o, out_data_o, out_first_o, out_last_o, out_len_o, out_zero_o, err_start_o}, 0);
      @(negedge clk); rst_n = 1'b1;
      #1 check("ready_at_release", in_ready_o, 0);
      @(posedge clk); #1;
      check("ready_after_release", in_ready_o, 1);

      // 1: only index 0 nonzero, full replay, 2-cycle latency
      ready_mode = 1;
      for (int unsigned i = 0; i < BLK; i++) cur_blk[i] = 16'h0;
      cur_blk[0] = 16'd5;
      obs_q.delete();
      send_block(0, BLK);
      check("lat_edge0", out_valid_o, 0);
      wait_cycles(1);
      check("lat_edge1", out_valid_o, 0);
      wait_cycles(1);
      check("lat_edge2", out_valid_o, 1);
      wait_drain();
      if (obs_q.size() == 1) begin
         o = obs_q.pop_front();
         check("t1_beats", o.beats, 64);
         check("t1_meta", {o.first_data, o.len, o.zero}, {16'd5, 6'd0, 1'b0});
      end else check("t1_blocks", obs_q.size(), 1);

      // 2: nonzero at 3 and 40, truncated
      for (int unsigned i = 0; i < BLK; i++) cur_blk[i] = 16'h0;
      cur_blk[3] = 16'hFFF9; cur_blk[40] = 16'd123;
      send_block(1, BLK);
      wait_drain();
      if (obs_q.size() == 1) begin
         o = obs_q.pop_front();
         check("t2_beats", o.beats, 41);
         check("t2_meta", {o.len, o.zero}, {6'd40, 1'b0});
      end else check("t2_blocks", obs_q.size(), 1);

      // 3: all-zero block, truncated
      for (int unsigned i = 0; i < BLK; i++) cur_blk[i] = 16'h0;
      send_block(1, BLK);
      wait_drain();
      if (obs_q.size() == 1) begin
         o = obs_q.pop_front();
         check("t3_beats", o.beats, 1);
         check("t3_meta", {o.first_data, o.len, o.zero}, {16'd0, 6'd0, 1'b1});
      end else check("t3_blocks", obs_q.size(), 1);

      // 4: three back-to-back blocks with output stalled
      ready_mode = 0;
      wait_cycles(2);
      fill_random(60, BLK);
      send_block(0, BLK);
      fill_random(30, 25);
      send_block(1, BLK);
      check("ready_low_after_2nd", in_ready_o, 0);
      fill_random(50, BLK);
      fork
         send_block(0, BLK);
         begin
            wait_cycles(20);
            check("ready_still_low", in_ready_o, 0);
            ready_mode = 1;
         end
      join
      wait_drain();
      check("t4_blocks", obs_q.size(), 3);
      obs_q.delete();

      // 5: restart at wr_idx 20, then a stray beat while idle
      e0 = err_cnt;
      fill_random(50, BLK);
      send_block(0, 20);
      fill_random(40, BLK);
      send_block(0, BLK);
      wait_cycles(3);
      check("abort_err_pulses", err_cnt - e0, 1);
      wait_drain();
      check("t5_blocks", obs_q.size(), 1);
      obs_q.delete();
      e0 = err_cnt;
      send_beat(16'h1234, 0, 0);
      in_valid = 1'b0;
      wait_cycles(3);
      check("drop_err_pulses", err_cnt - e0, 1);
      wait_drain();

      // 6: random output backpressure
      ready_mode = 2;
      for (int unsigned k = 0; k < 3; k++) begin
         fill_random(40, (k == 1) ? 30 : BLK);
         send_block(k == 1, BLK);
      end
      wait_drain();
      ready_mode = 1;
      check("t6_blocks", obs_q.size(), 3);
      obs_q.delete();

      // 7: reset mid-block discards everything
      fill_random(50, BLK);
      send_block(0, 30);
      rst_n = 1'b0;
      wait_cycles(2);
      @(negedge clk); rst_n = 1'b1;
      saw = 0;
      for (int unsigned i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid_o) saw = 1;
      end
      check("no_replay_after_reset", saw, 0);
      check("ready_after_mid_reset", in_ready_o, 1);

      check("model_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ac_last_nz_buffer.md
# ac_last_nz_buffer

Parametrised block buffer that captures one zig-zag-ordered block of BLK_LEN quantised coefficients, finds the index of the last non-zero coefficient and replays the block to the entropy coder. It sits between the quantiser/zig-zag stage and the run-length/Huffman stage. Ping-pong banking accepts back-to-back blocks without gaps. Valid/ready handshakes on both sides and an optional truncated replay mode extend the older fixed 64-entry, fixed-timing buffer.

## Interface
- DATA_WIDTH, 16, coefficient width (two's complement).
- BLK_LEN, 64, coefficients per block; must be a power of two, at least 4.
- IDX_WIDTH, $clog2(BLK_LEN), width of coefficient indices.

- clk_x8_i  in  1  pixel-x8 clock; the only clock.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o.
- in_start_i  in  1  marks beat index 0 of a block.
- in_data_i  in  DATA_WIDTH  coefficient.
- mode_trunc_i  in  1  sampled on the start beat; 1 = replay only indices 0..last index.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts the beat.
- out_data_o  out  DATA_WIDTH  coefficient.
- out_first_o  out  1  beat is index 0.
- out_last_o  out  1  final beat of the replay.
- out_len_o  out  IDX_WIDTH  index of the last non-zero coefficient; 0 if there is none.
- out_zero_o  out  1  every coefficient of the block is zero.
- err_start_o  out  1  one-cycle pulse on a protocol error.

## Operation
- Two banks, each BLK_LEN x DATA_WIDTH, each with a FULL flag and metadata: last index, zero flag, trunc flag.
- Write side:
  - wr_idx counts accepted beats.
  - A beat with in_start_i forces index 0.
  - Beats arriving while idle without in_start_i are dropped, and err_start_o pulses.
  - in_start_i at wr_idx != 0 aborts the partial block: err_start_o pulses, the bank is not committed, and writing restarts at index 0 with this beat.
- Last-index tracking:
  - On each accepted beat with nonzero data, run_last <= wr_idx and run_nz <= 1.
  - The start beat reinitialises both to the beat's own result.
- Commit: on the beat with wr_idx == BLK_LEN-1, the write bank is marked FULL, its metadata is latched, and the write bank pointer toggles.
- in_ready_o = !FULL[write bank].
- Read side: when FULL[read bank] is set, words are streamed out. The replay count is last index + 1 if trunc is set, otherwise BLK_LEN. An all-zero block in trunc mode replays one beat, index 0.
- After the handshake of the out_last_o beat, FULL[read bank] clears and the read bank pointer toggles.
- Metadata outputs are constant over every beat of a replay.
- Output data is held stable while out_valid_o && !out_ready_i.
- Simultaneous commit on one bank and release of the other in the same cycle are both honoured.

## Timing
- Reset values: all outputs 0; FULL flags 0; both pointers at bank 0; wr_idx 0; write side idle.
- in_ready_o is 1 one cycle after reset release.
- Memory read is synchronous.
- The first out_valid_o is asserted 2 cycles after the commit beat's clock edge, provided the read side is idle.
- With out_ready_i held at 1, one beat is produced per cycle with no bubbles between consecutive blocks.
- Input throughput is 1 beat per cycle sustained when the output drains at rate 1.
- Asserting rst_n_i low mid-block discards all buffered data immediately; no partial replay follows.

## Structure
- Package ac_pkg holds:
  - bank-state typedef (bank index, FULL flag, metadata struct {last idx, zero, trunc});
  - helper constants derived from BLK_LEN.
- Sub-module ac_bank_ram: simple dual-port synchronous RAM (one write port, one read port), depth 2*BLK_LEN, with the bank pointer as the address MSB.
- The top level holds the write counter, last-index tracker, bank flags, read sequencer and output skid register.

## Test plan
- Block with only index 0 = 5, default mode, out_ready_i = 1 -> 64 beats; out_len_o = 0, out_zero_o = 0; out_first_o on beat 0 (data 5), out_last_o on beat 63.
- Nonzero at indices 3 and 40, mode_trunc_i = 1 -> 41 beats; out_len_o = 40; out_last_o on index 40.
- All-zero block with mode_trunc_i = 1 -> 1 beat of data 0; out_zero_o = 1, out_len_o = 0, out_first_o = out_last_o = 1.
- Three back-to-back blocks with out_ready_i = 0 -> in_ready_o falls after the second commit. Then release out_ready_i -> all blocks replay in order, and the third block is accepted with no data loss.
- in_start_i re-asserted at wr_idx = 20 -> err_start_o pulses once; only the restarted block is replayed.
- Random out_ready_i toggling -> out_data_o is stable while stalled; beat count and order match the reference model.
